// File: rtl/sd_char_stats_pkg.sv
// Shared types and constants for the character statistics block.
// Holds the FSM state encoding, LED colour codes and the report index width.
// Also provides the ASCII case-fold helper used ahead of target comparison.
package sd_char_stats_pkg;

   typedef enum logic [1:0] {
      ST_COUNT  = 2'd0,
      ST_REPORT = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam logic [2:0] RGB_OFF   = 3'b000;
   localparam logic [2:0] RGB_RED   = 3'b100;
   localparam logic [2:0] RGB_GREEN = 3'b010;
   localparam logic [2:0] RGB_BLUE  = 3'b001;

   // Report words carry a 4-bit counter index above the count.
   localparam int IDX_W = 4;

   // Map 'A'..'Z' onto 'a'..'z' when folding is enabled; other bytes pass through.
   function automatic logic [7:0] fold_byte(input logic [7:0] b, input bit en);
      if (en && (b >= 8'h41) && (b <= 8'h5A)) begin
         return b + 8'h20;
      end
      return b;
   endfunction

endpackage

// File: rtl/sd_char_stats_sat_counter.sv
// Saturating event counter with a sticky overflow flag.
// Latency: count and flag update on the edge after inc_i; clr_i wins over inc_i.
// Backpressure: none; an increment at full scale holds the value and sets ovf_o.
module sd_sat_counter #(
   parameter int CNT_W = 24
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             ovf_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;

   // Next-state: clear, saturate-and-flag, or plain increment.
   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (clr_i) begin
         cnt_d = '0;
         ovf_d = 1'b0;
      end else if (inc_i) begin
         if (&cnt_q) begin
            ovf_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Count and sticky flag registers.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   assign cnt_o = cnt_q;
   assign ovf_o = ovf_q;

endmodule

// File: rtl/sd_char_stats.sv
// Counts configurable target characters plus total bytes of a file stream, then reports them.
// Latency: counts land one edge after outen; report word 0 is valid the cycle after endFile.
// Backpressure: report words hold while r_tvalid && !r_tready; stream bytes outside COUNT are dropped.
module sd_char_stats
   import sd_char_stats_pkg::*;
#(
   parameter int                    NUM_CHAN  = 4,
   parameter logic [8*NUM_CHAN-1:0] TARGETS   = {8'h61, 8'h65, 8'h20, 8'h0A},
   parameter bit                    CASE_FOLD = 1'b1,
   parameter int                    CNT_W     = 24,
   parameter int                    BLINK_W   = 24
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   outen,
   input  logic [7:0]             outbyte,
   input  logic                   endFile,
   input  logic                   clr,
   input  logic [2:0]             sel,
   output logic [15:0]            led,
   output logic [2:0]             rgb_led,
   output logic                   done,
   output logic [NUM_CHAN:0]      ovf,
   output logic                   r_tvalid,
   input  logic                   r_tready,
   output logic [CNT_W+IDX_W-1:0] r_tdata
);

   state_t                 state_q;
   logic [IDX_W-1:0]       idx_q;
   logic                   r_tvalid_q;
   logic                   done_q;
   logic [CNT_W+IDX_W-1:0] r_tdata_q;
   logic [15:0]            led_q;
   logic [2:0]             rgb_q;
   logic [BLINK_W-1:0]     blink_q;

   logic [CNT_W-1:0]       cnt_w [0:NUM_CHAN];
   logic [NUM_CHAN:0]      ovf_w;
   logic [NUM_CHAN:0]      inc_w;
   logic [7:0]             byte_f;
   logic                   count_en;
   logic [IDX_W-1:0]       nxt_idx;
   logic [CNT_W-1:0]       nxt_word;
   logic [CNT_W-1:0]       sel_cnt;
   logic [CNT_W-1:0]       entry_cnt;

   // Fold and compare the incoming byte; total counts every accepted byte.
   always_comb begin
      byte_f   = fold_byte(outbyte, CASE_FOLD);
      count_en = (state_q == ST_COUNT) && outen && !clr;
      inc_w    = '0;
      inc_w[NUM_CHAN] = count_en;
      for (int i = 0; i < NUM_CHAN; i++) begin
         inc_w[i] = count_en && (byte_f == TARGETS[8*(NUM_CHAN-1-i) +: 8]);
      end
   end

   for (genvar g = 0; g <= NUM_CHAN; g++) begin : g_cnt
      sd_sat_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk_i  (clk),
         .rstn_i (rstn),
         .clr_i  (clr),
         .inc_i  (inc_w[g]),
         .cnt_o  (cnt_w[g]),
         .ovf_o  (ovf_w[g])
      );
   end

   // Report-word and LED selection muxes over the counter bank.
   always_comb begin
      nxt_idx  = idx_q + IDX_W'(1);
      nxt_word = '0;
      sel_cnt  = '0;
      for (int i = 0; i <= NUM_CHAN; i++) begin
         if (nxt_idx == IDX_W'(i)) nxt_word = cnt_w[i];
         if ({1'b0, sel} == IDX_W'(i)) sel_cnt = cnt_w[i];
      end
      // Word 0 is loaded on the same edge that counts a byte arriving with endFile,
      // so it must already include that increment.
      entry_cnt = (inc_w[0] && !(&cnt_w[0])) ? cnt_w[0] + CNT_W'(1) : cnt_w[0];
   end

   // Control FSM with registered report outputs and done flag.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ST_COUNT;
         idx_q      <= '0;
         r_tvalid_q <= 1'b0;
         r_tdata_q  <= '0;
         done_q     <= 1'b0;
      end else if (clr) begin
         state_q    <= ST_COUNT;
         idx_q      <= '0;
         r_tvalid_q <= 1'b0;
         r_tdata_q  <= '0;
         done_q     <= 1'b0;
      end else begin
         case (state_q)
            ST_COUNT: begin
               if (endFile) begin
                  state_q    <= ST_REPORT;
                  idx_q      <= '0;
                  r_tvalid_q <= 1'b1;
                  r_tdata_q  <= {IDX_W'(0), entry_cnt};
               end
            end
            ST_REPORT: begin
               if (r_tvalid_q && r_tready) begin
                  if (idx_q == IDX_W'(NUM_CHAN)) begin
                     state_q    <= ST_DONE;
                     r_tvalid_q <= 1'b0;
                     done_q     <= 1'b1;
                  end else begin
                     idx_q      <= nxt_idx;
                     r_tdata_q  <= {nxt_idx, nxt_word};
                  end
               end
            end
            default: begin
               done_q <= 1'b1;
            end
         endcase
      end
   end

   // Free-running divider for the blinking status colour.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) blink_q <= '0;
      else       blink_q <= blink_q + BLINK_W'(1);
   end

   // Registered LED mux and status colour.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         led_q <= '0;
         rgb_q <= RGB_OFF;
      end else begin
         led_q <= 16'(sel_cnt);
         if (|ovf_w)                                        rgb_q <= RGB_RED;
         else if (state_q == ST_DONE)                       rgb_q <= RGB_GREEN;
         else if (state_q == ST_REPORT)                     rgb_q <= RGB_BLUE;
         else if ((cnt_w[NUM_CHAN] != '0) && blink_q[BLINK_W-1]) rgb_q <= RGB_BLUE;
         else                                               rgb_q <= RGB_OFF;
      end
   end

   assign led      = led_q;
   assign rgb_led  = rgb_q;
   assign done     = done_q;
   assign ovf      = ovf_w;
   assign r_tvalid = r_tvalid_q;
   assign r_tdata  = r_tdata_q;

endmodule

// File: tb/tb_sd_char_stats.sv
// Two instances share one stimulus stream: default widths and a 4-bit counter variant.
// Expected counts come from a byte-level reference model with saturation applied per width.
module tb_sd_char_stats;

   logic       clk = 1'b0;
   logic       rstn = 1'b1;
   logic       outen = 1'b0;
   logic [7:0] outbyte = 8'h00;
   logic       endFile = 1'b0;
   logic       clr = 1'b0;
   logic [2:0] sel = 3'd0;
   logic       r_tready = 1'b0;

   logic [15:0] led_m, led_s;
   logic [2:0]  rgb_m, rgb_s;
   logic        done_m, done_s;
   logic [4:0]  ovf_m, ovf_s;
   logic        r_tvalid_m, r_tvalid_s;
   logic [27:0] r_tdata_m;
   logic [7:0]  r_tdata_s;

   int checks = 0;
   int errors = 0;

   int m_cnt [0:4];
   bit m_counting = 1'b1;
   logic [7:0] tgt [0:3];

   always #5 clk = ~clk;

   sd_char_stats u_dut (
      .clk(clk), .rstn(rstn), .outen(outen), .outbyte(outbyte), .endFile(endFile),
      .clr(clr), .sel(sel), .led(led_m), .rgb_led(rgb_m), .done(done_m), .ovf(ovf_m),
      .r_tvalid(r_tvalid_m), .r_tready(r_tready), .r_tdata(r_tdata_m)
   );

   sd_char_stats #(.CNT_W(4)) u_sat (
      .clk(clk), .rstn(rstn), .outen(outen), .outbyte(outbyte), .endFile(endFile),
      .clr(clr), .sel(sel), .led(led_s), .rgb_led(rgb_s), .done(done_s), .ovf(ovf_s),
      .r_tvalid(r_tvalid_s), .r_tready(r_tready), .r_tdata(r_tdata_s)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int satv(input int v, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   function automatic logic [4:0] exp_ovf(input int w);
      logic [4:0] r;
      for (int i = 0; i < 5; i++) r[i] = (m_cnt[i] > ((1 << w) - 1));
      return r;
   endfunction

   function automatic logic [7:0] lower(input logic [7:0] b);
      return (b >= "A" && b <= "Z") ? b + 8'd32 : b;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 5; i++) m_cnt[i] = 0;
      m_counting = 1'b1;
   endtask

   task automatic model_byte(input logic [7:0] b);
      if (m_counting) begin
         m_cnt[4]++;
         for (int i = 0; i < 4; i++) if (lower(b) == tgt[i]) m_cnt[i]++;
      end
   endtask

   // All drives happen at negedge; the following posedge acts on them.
   task automatic send(input logic [7:0] b);
      outen = 1'b1; outbyte = b; model_byte(b);
      @(negedge clk);
      outen = 1'b0;
   endtask

   task automatic end_file(input bit with_byte, input logic [7:0] b);
      endFile = 1'b1;
      if (with_byte) begin outen = 1'b1; outbyte = b; model_byte(b); end
      m_counting = 1'b0;
      @(negedge clk);
      endFile = 1'b0; outen = 1'b0;
   endtask

   task automatic do_clear();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      model_clear();
   endtask

   // Drain the report (mode 0 always ready, 1 toggling, 2 random) up to 'stop' words.
   task automatic collect(input int mode, input int stop);
      int k = 0; int cyc = 0; bit stall = 0; bit tog = 1; bit rdy;
      logic [27:0] pm = '0; logic [7:0] ps = '0;
      logic [27:0] em; logic [7:0] es;
      while (k < stop && cyc < 200) begin
         chk("tvalid_in_report", r_tvalid_m, 1);
         if (stall) begin
            chk("stall_hold_main", r_tdata_m, pm);
            chk("stall_hold_sat", r_tdata_s, ps);
         end
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = tog;
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         tog = !tog;
         if (rdy && r_tvalid_m) begin
            em = {4'(k), 24'(satv(m_cnt[k], 24))};
            es = {4'(k), 4'(satv(m_cnt[k], 4))};
            chk($sformatf("word%0d_main", k), r_tdata_m, em);
            chk($sformatf("word%0d_sat", k), r_tdata_s, es);
            k++;
         end
         stall = !rdy; pm = r_tdata_m; ps = r_tdata_s;
         r_tready = rdy;
         @(negedge clk);
         cyc++;
      end
      r_tready = 1'b0;
      chk("report_word_count", k, stop);
      if (stop == 5) begin
         chk("tvalid_after_last", r_tvalid_m, 0);
         chk("tvalid_after_last_sat", r_tvalid_s, 0);
         chk("done_after_report", done_m, 1);
         chk("ovf_main", ovf_m, exp_ovf(24));
         chk("ovf_sat", ovf_s, exp_ovf(4));
      end
   endtask

   initial begin
      string s;
      int n;
      logic [7:0] pool [0:5];
      tgt[0] = 8'h61; tgt[1] = 8'h65; tgt[2] = 8'h20; tgt[3] = 8'h0A;
      pool[0] = "a"; pool[1] = "A"; pool[2] = "e"; pool[3] = "E"; pool[4] = " "; pool[5] = 8'h0A;
      model_clear();

      // Reset values
      #2 rstn = 1'b0;
      @(negedge clk);
      chk("rst_led", led_m, 0);
      chk("rst_rgb", rgb_m, 0);
      chk("rst_done", done_m, 0);
      chk("rst_ovf", ovf_m, 0);
      chk("rst_tvalid", r_tvalid_m, 0);
      chk("rst_tdata", r_tdata_m, 0);
      rstn = 1'b1;
      @(negedge clk);

      // "Hello World\n" then full-speed report
      s = "Hello World\n";
      for (int i = 0; i < s.len(); i++) send(s[i]);
      end_file(1'b0, 8'h00);
      collect(0, 5);
      @(negedge clk);
      chk("rgb_done_green", rgb_m, 3'b010);

      // LED selection of total and of an out-of-range index
      sel = 3'd4;
      @(negedge clk); @(negedge clk);
      chk("led_total", led_m, 16'd12);
      chk("led_total_sat", led_s, 16'd12);
      sel = 3'd7;
      @(negedge clk); @(negedge clk);
      chk("led_sel7", led_m, 16'd0);

      // Byte with endFile is counted; bytes during REPORT are ignored
      do_clear();
      send("E"); send("x"); send("a");
      end_file(1'b1, "e");
      r_tready = 1'b0;
      send("e"); send("a"); send(" ");
      collect(2, 5);
      sel = 3'd1;
      @(negedge clk); @(negedge clk);
      chk("led_ch1_e", led_m, 16'd2);

      // Random streams with varied backpressure
      for (int r = 0; r < 4; r++) begin
         do_clear();
         n = $urandom_range(5, 40);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            if ($urandom_range(0, 1) == 1) send(pool[$urandom_range(0, 5)]);
            else send(8'($urandom_range(0, 255)));
         end
         end_file(1'b0, 8'h00);
         collect((r % 2 == 0) ? 1 : 2, 5);
      end

      // clr mid-report after two words
      do_clear();
      for (int i = 0; i < 9; i++) send(pool[$urandom_range(0, 5)]);
      end_file(1'b0, 8'h00);
      collect(1, 2);
      sel = 3'd4;
      clr = 1'b1; r_tready = 1'b1;
      @(negedge clk);
      clr = 1'b0; r_tready = 1'b0;
      model_clear();
      chk("clr_tvalid_drop", r_tvalid_m, 0);
      chk("clr_done_low", done_m, 0);
      @(negedge clk);
      chk("clr_led_total", led_m, 0);
      chk("clr_rgb_off", rgb_m, 3'b000);
      sel = 3'd0;
      send("a");
      @(negedge clk);
      chk("clr_back_to_count", led_m, 16'd1);

      // Saturation on the 4-bit instance
      do_clear();
      for (int i = 0; i < 20; i++) send("a");
      sel = 3'd0;
      @(negedge clk); @(negedge clk);
      chk("sat_ch0", led_s, 16'd15);
      chk("nosat_ch0", led_m, 16'd20);
      sel = 3'd4;
      @(negedge clk); @(negedge clk);
      chk("sat_total", led_s, 16'd15);
      chk("sat_ovf", ovf_s, 5'b10001);
      chk("nosat_ovf", ovf_m, 5'b00000);
      chk("sat_rgb_red", rgb_s, 3'b100);

      // Asynchronous reset away from any clock edge
      #3 rstn = 1'b0;
      #1;
      chk("arst_led", led_s, 0);
      chk("arst_ovf", ovf_s, 0);
      chk("arst_rgb", rgb_s, 0);
      chk("arst_tvalid", r_tvalid_s, 0);
      chk("arst_tdata", r_tdata_m, 0);
      chk("arst_done", done_m, 0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
